// File: rtl/vector_tile_if.sv
// Vector tile bus between an execution module (master) and the buffer bank (slave):
// single-cycle read/write tile requests, registered read return, and pointer rewind.
interface vector_tile_if #(
    parameter int DATA_WIDTH = 8,
    parameter int TILE_WIDTH = 256
);
    localparam int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH;
    localparam int TILE_BITS  = TILE_ELEMS * DATA_WIDTH;

    logic                        vec_read_enable;
    logic [4:0]                  vec_read_buffer_id;
    logic signed [TILE_BITS-1:0] vec_read_tile;
    logic                        vec_read_valid;
    logic                        vec_write_enable;
    logic [4:0]                  vec_write_buffer_id;
    logic signed [TILE_BITS-1:0] vec_write_tile;
    logic                        ptr_clear;
    logic [4:0]                  ptr_clear_buffer_id;

    modport master (
        output vec_read_enable, vec_read_buffer_id,
        output vec_write_enable, vec_write_buffer_id, vec_write_tile,
        output ptr_clear, ptr_clear_buffer_id,
        input  vec_read_tile, vec_read_valid
    );

    modport slave (
        input  vec_read_enable, vec_read_buffer_id,
        input  vec_write_enable, vec_write_buffer_id, vec_write_tile,
        input  ptr_clear, ptr_clear_buffer_id,
        output vec_read_tile, vec_read_valid
    );
endinterface

// File: rtl/vector_buffer_bank.sv
// Bank of independent tile buffers with per-buffer auto-incrementing read/write pointers.
// Optional macro VEC_BUF_RAW_BYPASS_EN forwards same-cycle write data to a colliding read.
module vector_buffer_bank #(
    parameter int DATA_WIDTH  = 8,
    parameter int TILE_WIDTH  = 256,
    parameter int TILE_ELEMS  = TILE_WIDTH / DATA_WIDTH,
    parameter int NUM_BUFFERS = 4,
    parameter int BUF_TILES   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    vector_tile_if.slave  bus,
    output logic          rd_err,
    output logic          wr_err
);
    localparam int TW    = TILE_ELEMS * DATA_WIDTH;
    localparam int PTR_W = (BUF_TILES > 1) ? $clog2(BUF_TILES) : 1;
    localparam int IDX_W = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;

    typedef logic [PTR_W-1:0] ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        if (p == PTR_W'(BUF_TILES - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    function automatic logic id_in_range(input logic [4:0] id);
        return ({1'b0, id} < 6'(NUM_BUFFERS));
    endfunction

    logic signed [TW-1:0] r_mem [NUM_BUFFERS][BUF_TILES];
    ptr_t                 r_rd_ptr [NUM_BUFFERS];
    ptr_t                 r_wr_ptr [NUM_BUFFERS];

    logic                 r_vld_p1;
    logic signed [TW-1:0] r_tile_p1;
    logic                 r_rd_err_p1;
    logic                 r_wr_err_p1;

    logic                 w_rd_acc;
    logic                 w_wr_acc;
    logic                 w_clr_acc;
    logic [IDX_W-1:0]     w_rd_idx;
    logic [IDX_W-1:0]     w_wr_idx;
    logic [IDX_W-1:0]     w_clr_idx;
    logic signed [TW-1:0] w_rd_data;

    assign w_rd_acc  = bus.vec_read_enable  && id_in_range(bus.vec_read_buffer_id);
    assign w_wr_acc  = bus.vec_write_enable && id_in_range(bus.vec_write_buffer_id);
    assign w_clr_acc = bus.ptr_clear        && id_in_range(bus.ptr_clear_buffer_id);
    assign w_rd_idx  = bus.vec_read_buffer_id[IDX_W-1:0];
    assign w_wr_idx  = bus.vec_write_buffer_id[IDX_W-1:0];
    assign w_clr_idx = bus.ptr_clear_buffer_id[IDX_W-1:0];

    // ---- p0: tile storage (not reset; write uses the pre-clear pointer)
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_wr_idx][r_wr_ptr[w_wr_idx]] <= bus.vec_write_tile;
        end
    end

    always_comb begin
        w_rd_data = r_mem[w_rd_idx][r_rd_ptr[w_rd_idx]];
`ifdef VEC_BUF_RAW_BYPASS_EN
        if (w_wr_acc && (w_wr_idx == w_rd_idx) &&
            (r_wr_ptr[w_wr_idx] == r_rd_ptr[w_rd_idx])) begin
            w_rd_data = bus.vec_write_tile;
        end
`endif
    end

    // ---- p0: pointer update; clear overrides any same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BUFFERS; b++) begin
                r_rd_ptr[b] <= '0;
                r_wr_ptr[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BUFFERS; b++) begin
                if (w_clr_acc && (w_clr_idx == IDX_W'(b))) begin
                    r_rd_ptr[b] <= '0;
                    r_wr_ptr[b] <= '0;
                end else begin
                    if (w_rd_acc && (w_rd_idx == IDX_W'(b))) begin
                        r_rd_ptr[b] <= ptr_inc(r_rd_ptr[b]);
                    end
                    if (w_wr_acc && (w_wr_idx == IDX_W'(b))) begin
                        r_wr_ptr[b] <= ptr_inc(r_wr_ptr[b]);
                    end
                end
            end
        end
    end

    // ---- p1: registered read return and error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1    <= 1'b0;
            r_rd_err_p1 <= 1'b0;
            r_wr_err_p1 <= 1'b0;
            r_tile_p1   <= '0;
        end else begin
            r_vld_p1    <= bus.vec_read_enable;
            r_rd_err_p1 <= bus.vec_read_enable && !w_rd_acc;
            r_wr_err_p1 <= bus.vec_write_enable && !w_wr_acc;
            if (w_rd_acc) begin
                r_tile_p1 <= w_rd_data;
            end else if (bus.vec_read_enable) begin
                r_tile_p1 <= '0;
            end
        end
    end

    assign bus.vec_read_valid = r_vld_p1;
    assign bus.vec_read_tile  = r_tile_p1;
    assign rd_err             = r_rd_err_p1;
    assign wr_err             = r_wr_err_p1;
endmodule

// File: doc/vector_buffer_bank.md
# vector_buffer_bank

Responder side of the execution-unit vector tile interface: a bank of independent vector buffers, selected by a 5-bit buffer id, that accepts whole-tile writes and returns whole tiles on read requests. Each buffer keeps its own auto-incrementing read and write tile pointers, so an execution module streams a vector by pulsing `vec_read_enable` or `vec_write_enable` once per tile without supplying addresses. The block sits in the buffer controller and serves ReLU and other element-wise execution modules.

## Interface
- `DATA_WIDTH`, 8: bits per signed element.
- `TILE_WIDTH`, 256: bits per tile.
- `TILE_ELEMS`, TILE_WIDTH/DATA_WIDTH: elements per tile.
- `NUM_BUFFERS`, 4: implemented buffers. Valid ids are 0..NUM_BUFFERS-1, with NUM_BUFFERS ≤ 32.
- `BUF_TILES`, 32: tiles per buffer, which is 1024 elements at default widths. Must be a power of two.

Ports:
- `clk`, in, 1: clock. Single clock domain.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `vec_read_enable`, in, 1: single-cycle read request.
- `vec_read_buffer_id`, in, 5: buffer to read.
- `vec_read_tile`, out, TILE_ELEMS×DATA_WIDTH signed: returned tile.
- `vec_read_valid`, out, 1: one-cycle pulse; `vec_read_tile` is valid in this cycle.
- `vec_write_enable`, in, 1: single-cycle write request.
- `vec_write_buffer_id`, in, 5: buffer to write.
- `vec_write_tile`, in, TILE_ELEMS×DATA_WIDTH signed: tile to store.
- `ptr_clear`, in, 1: rewinds both pointers of one buffer.
- `ptr_clear_buffer_id`, in, 5: buffer to rewind.
- `rd_err`, out, 1: pulse coincident with `vec_read_valid` for an out-of-range id.
- `wr_err`, out, 1: pulse one cycle after an out-of-range write.

## Operation
- Each buffer b holds:
  - `rd_ptr[b]` and `wr_ptr[b]`, each log2(BUF_TILES) bits.
  - BUF_TILES tile entries.
- **Write accepted** (`vec_write_enable`=1, id < NUM_BUFFERS):
  - `mem[id][wr_ptr[id]]` ← `vec_write_tile`.
  - `wr_ptr[id]` increments, wrapping BUF_TILES-1 → 0.
- **Read accepted** (`vec_read_enable`=1, id < NUM_BUFFERS):
  - Next cycle, `vec_read_tile` = `mem[id][rd_ptr[id]]` and `vec_read_valid`=1.
  - `rd_ptr[id]` increments with the same wrap.
- **Out-of-range id:**
  - Read: `vec_read_valid` still pulses next cycle, `vec_read_tile` is all zeros, `rd_err`=1. No pointer changes.
  - Write: dropped, `wr_err`=1 next cycle.
- **`ptr_clear`:** sets `rd_ptr` and `wr_ptr` of the named buffer to 0 at the clock edge. An out-of-range clear id is ignored and raises no error.
- **Simultaneous events:**
  - Read and write to different buffers in one cycle: both serviced independently.
  - Read and write to the same buffer at the same tile index: read returns the old contents unless the bypass is compiled in (see Configuration).
  - `ptr_clear` in the same cycle as a read or write on that buffer: the access uses the pre-clear pointer, and clear wins the pointer update, so the pointer ends at 0.
- Reading past the last written tile returns stale or uninitialised contents. This is not an error and is not flagged.
- No backpressure. Requests are accepted every cycle, and back-to-back reads produce back-to-back valid pulses.

## Timing
- Read latency is exactly 1 cycle, from the request edge to `vec_read_valid`. `vec_read_tile` is registered and holds until the next valid pulse.
- Write data is visible to a read issued in the following cycle or later.
- Reset values:
  - `vec_read_valid`=0, `rd_err`=0, `wr_err`=0.
  - `vec_read_tile` all zeros.
  - All pointers 0.
  - Memory contents are not reset.
- Reset asserted mid-stream: outputs go to reset values immediately (asynchronous), any in-flight read produces no valid pulse, and pointers return to 0.
- Deassertion of `rst_n` is synchronised externally. The first request is honoured on the first edge with `rst_n`=1.

## Configuration
- `VEC_BUF_RAW_BYPASS_EN`
  - Defined: a same-cycle read and write to the same buffer and same tile index returns `vec_write_tile` (the new data) on the following valid pulse.
  - Undefined: the read returns the previously stored tile (read-before-write). No forwarding logic is instantiated.

## Test plan
- **Stream write then read:** after reset, write 4 tiles to buffer 2 (tile k filled with value k+1), then `ptr_clear` buffer 2 and pulse 4 reads → valid pulses carry tiles 1,2,3,4 in order, each 1 cycle after its request.
- **Interleaved buffers:** write tile A (all 5) to buffer 0 and tile B (all −3) to buffer 1, then read buffer 1 then buffer 0 → returns B then A; `rd_ptr` advances only on the buffer read.
- **Wrap-around:** write 33 tiles to buffer 3 (tile k = k), then clear and read 1 tile → returns 32, because the write pointer wrapped and overwrote tile 0.
- **Out-of-range ids:** read id 7 → valid pulse with all-zero tile and `rd_err`=1. Write id 9 → `wr_err`=1 next cycle, and no pointer of buffers 0..3 changes.
- **Collision:** with buffer 0 pointers at 0 and tile 0 holding all 1, issue a same-cycle write of all 9 and a read → returns all 1 without `VEC_BUF_RAW_BYPASS_EN`, all 9 with it.
- **Reset mid-read:** pulse a read, then assert `rst_n`=0 before the next edge → no valid pulse, outputs zero, and the pointers of all buffers read 0 afterwards (next read after a write of X returns X).
